// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared FSM encoding and sizing helper for the divider
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold the values 0..v-1; used with v = WIDTH+1 for the step counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/done request and result bundle for the divider
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_sub.sv
// rtl/seq_restoring_divider_sub.sv - full subtractor cell and ripple borrow-chain subtractor
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module ripple_borrow_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor u_fs (
      .a   (a[i]),
      .b   (b[i]),
      .bin (borrow[i]),
      .d   (diff[i]),
      .bout(borrow[i+1])
    );
  end

  // A borrow out of the top cell means a < b, i.e. the trial result went negative.
  assign bout = borrow[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic             last_step;
  logic             unused_rem_msb;

  // The partial remainder never exceeds the divisor, so its MSB is always shifted out as zero.
  assign rem_shifted    = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign unused_rem_msb = rem[WIDTH];
  assign last_step      = (count == CW'(1));

  ripple_borrow_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a   (rem_shifted),
    .b   ({1'b0, dsr}),
    .diff(trial),
    .bout(borrow)
  );

  always_comb begin
    rem_step = borrow ? rem_shifted : trial;
    q_step   = {q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rem    <= '0;
      q      <= '0;
      dsr    <= '0;
      count  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            dbz_q <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
              quot_q <= '1;
              rem_q  <= bus.dividend;
            end else begin
              dsr   <= bus.divisor;
              rem   <= '0;
              q     <= bus.dividend;
              count <= CW'(WIDTH);
            end
          end
        end
        ST_RUN: begin
          rem   <= rem_step;
          q     <= q_step;
          count <= count - CW'(1);
          // Publish on the final step so the results appear together with done.
          if (last_step) begin
            quot_q <= q_step;
            rem_q  <= rem_step[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (state == ST_RUN);
    bus.done        = (state == ST_DONE);
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule
